// File: rtl/div_seq32.sv
// ---------------------------------------------------------------------------
// div_seq32 -- sequential signed 32-bit divider using a restoring algorithm.
//
// One quotient bit is produced per clock. A divide takes 32 BUSY cycles and
// then one DONE cycle. A zero divisor skips BUSY and goes straight to DONE.
// The completion pulse and the result registers are loaded on the clock edge
// that leaves DONE, so data_resultRDY is high in the cycle after DONE.
//
// Ports
//   clock           rising-edge clock
//   resetn          asynchronous active-low reset
//   ctrl_div        start strobe; sampled only in IDLE
//   data_operandA   signed dividend, captured when a start is accepted
//   data_operandB   signed divisor, captured when a start is accepted
//   data_result     signed quotient, truncated toward zero; held until the
//                   next completion
//   data_resultRDY  one-cycle completion pulse
//   data_exception  divide-by-zero or 0x80000000 / -1 overflow; valid with
//                   data_resultRDY
//   busy            high while the FSM is in BUSY or DONE
//   data_remainder  (DIV_REMAINDER_EN only) signed remainder. Its sign
//                   follows the dividend. It is 0 on divide-by-zero.
//   state_dbg       current FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a start is accepted on a rising edge where the FSM is in IDLE
// and ctrl_div is 1. Starts seen in BUSY or DONE are dropped, not queued.
// Each accepted start produces exactly one data_resultRDY pulse, unless a
// reset intervenes.
//
// Configuration macro: DIV_REMAINDER_EN adds the data_remainder output.
// ---------------------------------------------------------------------------
module div_seq32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_next;
  logic [5:0]       count;
  logic [WIDTH-1:0] quo;      // holds the dividend magnitude, then fills with quotient bits
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic             ovf;

  logic             start;
  logic             last_step;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;

  // Magnitude of a two's-complement value. 0x80000000 maps to 2^31, which is
  // still correct when the result is read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign start     = (state == IDLE) && ctrl_div;
  assign last_step = (count == 6'(WIDTH - 1));
  assign busy      = (state == BUSY) || (state == DONE);
  assign state_dbg = state;

  // One restoring step. Shift the next dividend bit into the partial
  // remainder. Then subtract the divisor by adding its inverse with a
  // carry-in of 1. The subtraction is two bits wider than the operands, so
  // the top bit of the difference is the borrow flag.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    diff     = {1'b0, rem_sh} + ~{2'b00, dvs} + {{(WIDTH+1){1'b0}}, 1'b1};
    ge       = ~diff[WIDTH+1];
    rem_step = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ge};
  end

  always_comb begin
    quo_signed = neg_q ? (~quo + 1'b1) : quo;
    rem_signed = neg_r ? (~rem + 1'b1) : rem;
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_div) state_next = (data_operandB == '0) ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
    end else if (start) begin
      count <= '0;
      quo   <= mag(data_operandA);
      rem   <= '0;
      dvs   <= mag(data_operandB);
      neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      neg_r <= data_operandA[WIDTH-1];
      div0  <= (data_operandB == '0);
      ovf   <= (data_operandA == MIN_NEG) && (data_operandB == '1);
    end else if (state == BUSY) begin
      count <= count + 6'd1;
      quo   <= quo_step;
      rem   <= rem_step;
    end
  end

  // Result registers. These load on the edge that leaves DONE. They then
  // hold their value until the next operation completes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else if (state == DONE) begin
      data_resultRDY <= 1'b1;
      data_exception <= div0 | ovf;
      // The overflow case needs no special path. The magnitude quotient is
      // 2^31 and the signs agree, so the result is already 0x80000000.
      data_result    <= div0 ? '0 : quo_signed;
`ifdef DIV_REMAINDER_EN
      data_remainder <= div0 ? '0 : rem_signed;
`endif
    end else begin
      data_resultRDY <= 1'b0;
    end
  end

`ifndef DIV_REMAINDER_EN
  // The remainder is computed either way. It only has a consumer when the
  // remainder output is enabled.
  logic unused_rem;
  assign unused_rem = ^rem_signed;
`endif

endmodule

// File: tb/tb_div_seq32.sv
// ---------------------------------------------------------------------------
// tb_div_seq32 -- self-checking bench for div_seq32.
// Reference model: plain signed 64-bit division and modulo, plus the two
// exception rules. Expected values are queued when a start is driven and
// popped when the completion pulse appears.
// ---------------------------------------------------------------------------
module tb_div_seq32;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_exc_q[$];
  logic [31:0] exp_rem_q[$];

  div_seq32 dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference model built from the arithmetic rules
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic exc);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; exc = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); exc = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic exc;
    model(a, b, q, r, exc);
    exp_q.push_back(q);
    exp_rem_q.push_back(r);
    exp_exc_q.push_back({31'd0, exc});
  endtask

  // ---------------- driver ----------------
  // Drives a one-cycle start pulse and returns the index of the accepting
  // edge. The operands are scrambled right after capture.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int acc_edge);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_div = 1'b1;
    push_exp(a, b);
    acc_edge = cycle + 1;
    @(negedge clock);
    ctrl_div = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Waits (bounded) for the completion pulse and scores it.
  task automatic wait_rdy(input int exp_edge);
    bit seen;
    logic [31:0] held;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        seen = 1'b1;
        check("latency", 32'(cycle), 32'(exp_edge));
        check("busy_at_rdy", {31'd0, busy}, 32'd0);
        check("result", data_result, exp_q.pop_front());
        check("exception", {31'd0, data_exception}, exp_exc_q.pop_front());
`ifdef DIV_REMAINDER_EN
        check("remainder", data_remainder, exp_rem_q.pop_front());
`else
        void'(exp_rem_q.pop_front());
`endif
        held = data_result;
        @(negedge clock);
        check("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
        check("result_hold", data_result, held);
      end
    end
    if (!seen) begin
      check("rdy_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_exc_q.pop_front());
        void'(exp_rem_q.pop_front());
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    start_op(a, b, n);
    wait_rdy(n + ((b == 32'd0) ? 1 : 33));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, data_result, 32'd0);
    check({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_exc"}, {31'd0, data_exception}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
`ifdef DIV_REMAINDER_EN
    check({tag, "_rem"}, data_remainder, 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, n2;
    bit extra;
    logic [31:0] a, b;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // Directed cases
    run_op(32'd100, 32'd7);
    run_op(32'hFFFF_FF9C, 32'd7);
    run_op(32'd5, 32'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'h7FFF_FFFF, 32'd1);
    run_op(32'd7, 32'hFFFF_FFFD);

    // A start pulse in the middle of BUSY is ignored
    start_op(32'd20, 32'd3, n);
    repeat (8) @(negedge clock);
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    wait_rdy(n + 33);
    extra = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) extra = 1'b1;
    end
    check("no_second_rdy", {31'd0, extra}, 32'd0);
    check("idle_result_hold", data_result, 32'd6);

    // Reset in the middle of an operation aborts it
    start_op(32'd20, 32'd3, n);
    exp_q.delete();
    exp_exc_q.delete();
    exp_rem_q.delete();
    repeat (14) @(negedge clock);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    extra = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (data_resultRDY) extra = 1'b1;
    end
    resetn = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) extra = 1'b1;
    end
    check("no_rdy_after_abort", {31'd0, extra}, 32'd0);
    run_op(32'd9, 32'd3);

    // ctrl_div held high: the second start lands on the first IDLE cycle
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'hFFFF_FFF6;
    ctrl_div = 1'b1;
    push_exp(32'd1000, 32'hFFFF_FFF6);
    n = cycle + 1;
    @(negedge clock);
    data_operandA = 32'hFFFF_FC18;
    data_operandB = 32'd3;
    push_exp(32'hFFFF_FC18, 32'd3);
    n2 = n + 34;
    wait_rdy(n + 33);
    ctrl_div = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    wait_rdy(n2 + 33);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom;
          b = 32'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
        end
        3: begin a = 32'($urandom_range(0, 50)); b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
